tinyml_cmd_dispatch: RTL
========================

Name: tinyml_cmd_dispatch

Overview:
- Sits between the CPU custom-instruction port and the accelerator/user custom-instruction units.
- Routes each command by cmd_function_id[9]: 0 goes to the tinyML accelerator, 1 goes to the user custom unit.
- Tracks the target of every in-flight command in an order FIFO, so responses return to the CPU strictly in issue order.
- Registers the CPU response path in a one-entry output stage.

Parameters:
- ORDER_DEPTH, 4: maximum in-flight commands; power of 2, ≥2.
- ORDER_AW, 2: log2(ORDER_DEPTH).

Ports:
- clk  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  CPU command valid
- cmd_function_id  in  10  function ID; bit 9 selects the target
- cmd_inputs_0  in  32  operand 0
- cmd_inputs_1  in  32  operand 1
- cmd_ready  out  1  command accepted
- rsp_valid  out  1  registered response valid to CPU
- rsp_outputs_0  out  32  registered response data
- rsp_ready  in  1  CPU accepts response
- accel_cmd_valid  out  1  command valid to accelerator
- accel_cmd_ready  in  1  accelerator ready
- accel_rsp_valid  in  1  accelerator response valid
- accel_rsp_outputs_0  in  32  accelerator response data
- accel_rsp_ready  out  1  accelerator response accepted
- user_cmd_valid  out  1  command valid to user unit
- user_cmd_ready  in  1  user unit ready
- user_rsp_valid  in  1  user unit response valid
- user_rsp_outputs_0  in  32  user unit response data
- user_rsp_ready  out  1  user unit response accepted
- fwd_function_id  out  10  cmd_function_id, combinational pass-through
- fwd_inputs_0  out  32  cmd_inputs_0, combinational pass-through
- fwd_inputs_1  out  32  cmd_inputs_1, combinational pass-through
- outstanding  out  ORDER_AW+1  current order-FIFO occupancy

Behaviour:
- Reset state (asynchronous): rsp_valid=0, rsp_outputs_0=0, order FIFO empty, outstanding=0.
- Command path (combinational, zero latency):
  - sel = cmd_function_id[9].
  - accel_cmd_valid = cmd_valid & !sel & !full.
  - user_cmd_valid = cmd_valid & sel & !full.
  - cmd_ready = !full & (sel ? user_cmd_ready : accel_cmd_ready).
- Push: on cmd_valid & cmd_ready, push sel into the order FIFO. The FIFO holds 1-bit entries, with wrapping read/write pointers and a count.
- Full: cmd_ready=0 and both *_cmd_valid=0. There is no bypass; a pop and a push in the same cycle while full does not admit the command that cycle.
- Response selection:
  - head = FIFO head entry.
  - load_ok = !empty & (!rsp_valid | rsp_ready).
  - accel_rsp_ready = load_ok & (head==0).
  - user_rsp_ready = load_ok & (head==1).
  - The non-head target is held off (ready low) and its response is never dropped.
- Load: when the head target's rsp_valid and rsp_ready are both high:
  - capture its data into rsp_outputs_0 and set rsp_valid=1 next cycle;
  - pop the FIFO.
- Latency: target response to rsp_valid is 1 cycle. Throughput is 1 response/cycle while rsp_ready=1.
- Output drain: on rsp_valid & rsp_ready with no new load, rsp_valid clears next cycle. A load in the same cycle replaces the data (back-to-back).
- Empty FIFO: both *_rsp_ready=0; any target response arriving is ignored and held off.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Reset mid-operation: all state clears immediately, and in-flight commands are forgotten. Targets must be reset by the same reset.
- outstanding = count (0..ORDER_DEPTH). It does not include a response held in the output register.

Decomposition:
- Shared package tinyml_dispatch_pkg holds:
  - TGT_ACCEL=1'b0, TGT_USER=1'b1;
  - SEL_BIT=9;
  - ORDER_DEPTH default.
- One sub-module: tinyml_order_fifo (1-bit wide sync FIFO providing full, empty and count).
- Routing and the response register stay in the top.

Test Plan:
- Single accel cmd: id=0x005, accel_rsp 0x1234 three cycles later → rsp_valid one cycle after the accel response, rsp_outputs_0=0x1234, outstanding returns 1→0.
- Order enforcement: issue user id=0x200, then accel id=0x001. Accel responds first (0xAAAA), user responds two cycles later (0xBBBB) → accel_rsp_ready held low until the user response is accepted; CPU sees 0xBBBB then 0xAAAA.
- Full: 4 commands with no responses → outstanding=4. A 5th command sees cmd_ready=0 and both *_cmd_valid=0. One response popped → the 5th is accepted on the next cycle.
- Backpressure: rsp_ready=0 with 2 accel responses pending → first held in rsp_outputs_0, accel_rsp_ready=0. Release rsp_ready → back-to-back delivery with no bubble.
- Stray response: user_rsp_valid=1 while the FIFO is empty → user_rsp_ready=0, rsp_valid stays 0.
- Reset mid-flight: 3 outstanding, rsp_valid=1, assert reset asynchronously → rsp_valid=0, outstanding=0, cmd_ready follows target ready after release.

Source files
------------

// File: rtl/tinyml_dispatch_pkg.sv
// Shared constants and types for the tinyML command dispatcher.
// Target encodings match the routing bit of the function ID.
package tinyml_dispatch_pkg;

    typedef enum logic {
        TGT_ACCEL = 1'b0,
        TGT_USER  = 1'b1
    } target_e;

    localparam int SEL_BIT             = 9;
    localparam int ORDER_DEPTH_DEFAULT = 4;
    localparam int ORDER_AW_DEFAULT    = 2;

    function automatic target_e target_of(input logic [9:0] function_id);
        return target_e'(function_id[SEL_BIT]);
    endfunction

endpackage

// File: rtl/tinyml_order_fifo.sv
// One-bit-wide synchronous FIFO recording the target of each in-flight command.
// Push is ignored when full and pop is ignored when empty.
module tinyml_order_fifo
    import tinyml_dispatch_pkg::*;
#(
    parameter int DEPTH = ORDER_DEPTH_DEFAULT,
    parameter int AW    = ORDER_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_data,
    input  logic        pop,
    output logic        head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tinyml_cmd_dispatch.sv
// Routes CPU custom-instruction commands to the accelerator or user unit and
// returns responses in issue order through a one-entry registered output stage.
module tinyml_cmd_dispatch
    import tinyml_dispatch_pkg::*;
#(
    parameter int ORDER_DEPTH = ORDER_DEPTH_DEFAULT,
    parameter int ORDER_AW    = ORDER_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [9:0]        cmd_function_id,
    input  logic [31:0]       cmd_inputs_0,
    input  logic [31:0]       cmd_inputs_1,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_outputs_0,
    input  logic              rsp_ready,
    output logic              accel_cmd_valid,
    input  logic              accel_cmd_ready,
    input  logic              accel_rsp_valid,
    input  logic [31:0]       accel_rsp_outputs_0,
    output logic              accel_rsp_ready,
    output logic              user_cmd_valid,
    input  logic              user_cmd_ready,
    input  logic              user_rsp_valid,
    input  logic [31:0]       user_rsp_outputs_0,
    output logic              user_rsp_ready,
    output logic [9:0]        fwd_function_id,
    output logic [31:0]       fwd_inputs_0,
    output logic [31:0]       fwd_inputs_1,
    output logic [ORDER_AW:0] outstanding
);

    target_e     sel;
    logic        full;
    logic        empty;
    logic        head;
    logic        push;
    logic        load_ok;
    logic        load;
    logic [31:0] load_data;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;

    tinyml_order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .AW    (ORDER_AW)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (logic'(sel)),
        .pop       (load),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (outstanding)
    );

    // Command path is purely combinational; operands go to both targets.
    assign sel             = target_of(cmd_function_id);
    assign fwd_function_id = cmd_function_id;
    assign fwd_inputs_0    = cmd_inputs_0;
    assign fwd_inputs_1    = cmd_inputs_1;
    assign accel_cmd_valid = cmd_valid & (sel == TGT_ACCEL) & ~full;
    assign user_cmd_valid  = cmd_valid & (sel == TGT_USER) & ~full;
    assign cmd_ready       = ~full & ((sel == TGT_USER) ? user_cmd_ready : accel_cmd_ready);
    assign push            = cmd_valid & cmd_ready;

    // Only the target at the FIFO head may hand over a response.
    assign load_ok         = ~empty & (~rsp_valid_reg | rsp_ready);
    assign accel_rsp_ready = load_ok & (head == TGT_ACCEL);
    assign user_rsp_ready  = load_ok & (head == TGT_USER);
    assign load            = (accel_rsp_ready & accel_rsp_valid) |
                             (user_rsp_ready & user_rsp_valid);
    assign load_data       = (head == TGT_USER) ? user_rsp_outputs_0 : accel_rsp_outputs_0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else if (load) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_outputs_0 = rsp_data_reg;

endmodule
